// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// Moore-style main control unit for a multicycle MIPS datapath. It steps each
// instruction through fetch, decode, execute, memory and writeback, and waits
// in the memory states until the memory reports completion.
//
// Memory handshake: the controller holds MemRead (FETCH, MEMRD) or MemWrite
// (MEMWR) for as long as it stays in the access state. The access completes
// in the cycle where mem_ready=1, and the FSM leaves that state on the next
// rising edge. mem_ready is ignored in every other state.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   opcode[5:0]         IR[31:26], valid from DECODE onward
//   mem_ready           memory access completes this cycle
//   PCWrite/PCWriteCond unconditional / beq-conditional PC load
//   PCSource[1:0]       PC mux select: 00 ALU, 01 ALUOut, 10 jump target
//   IorD, MemRead, MemWrite, IRWrite   memory-side controls
//   MemtoReg, RegDst, RegWrite         register-file controls
//   ALUSrcA, ALUSrcB[1:0], ALUOp[1:0]  ALU operand and operation selects
//   illegal_op          one-cycle pulse for an unsupported opcode
//   state[3:0]          current state code (debug)
//   instret[CNT_W-1:0]  retired-instruction count, wraps
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_REXEC   = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_IEXEC   = 4'd11,
    S_IWB     = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  state_t cur;
  logic   retire;

  // An instruction retires on the edge that leaves its last state. A store
  // only finishes once memory accepts it, and ILLEGAL never counts.
  always_comb begin
    retire = 1'b0;
    case (cur)
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: retire = 1'b1;
      S_MEMWR:                                 retire = mem_ready;
      default:                                 retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= S_RST;
      instret <= '0;
    end else begin
      if (retire) instret <= instret + 1'b1;
      case (cur)
        S_RST:   cur <= S_FETCH;
        S_FETCH: if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: cur <= S_MEMADR;
            OP_RTYPE:     cur <= S_REXEC;
            OP_BEQ:       cur <= S_BRANCH;
            OP_J:         cur <= S_JUMP;
            OP_ADDI:      cur <= S_IEXEC;
            default:      cur <= S_ILLEGAL;
          endcase
        end
        // Only lw and sw reach MEMADR, so anything that is not lw is a store.
        S_MEMADR: cur <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) cur <= S_MEMWB;
        S_MEMWR:  if (mem_ready) cur <= S_FETCH;
        S_REXEC:  cur <= S_RWB;
        S_IEXEC:  cur <= S_IWB;
        // The PC was already advanced in FETCH, so ILLEGAL simply skips
        // the instruction. Codes 14/15 recover the same way.
        default:  cur <= S_FETCH;
      endcase
    end
  end

  // Outputs are decoded from the state, so reset clears them immediately,
  // including a memory request that was in progress. IRWrite and PCWrite in
  // FETCH also follow mem_ready: the IR and PC load only when the fetch
  // completes.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    illegal_op  = 1'b0;
    case (cur)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_IWB:     RegWrite   = 1'b1;
      S_ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm: a directed vector table walks one instruction
// of every kind (with memory stalls), then random instruction streams are
// checked against a per-instruction phase model, and finally reset is
// asserted in the middle of a store.
module tb_mc_control_fsm;
  localparam int CNT_W = 32;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0]       PCSource, ALUSrcB, ALUOp;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  mc_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .illegal_op(illegal_op), .state(state), .instret(instret)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- expected outputs per state ----------------
  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcsrc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic       ill;
  } outs_t;

  outs_t act_out;
  assign act_out = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
                    IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
                    ALUOp, illegal_op};

  function automatic outs_t exp_out(input int st, input logic mr);
    outs_t o;
    o = '0;
    case (st)
      1:  begin o.mrd = 1'b1; o.srcb = 2'b01; o.irw = mr; o.pcw = mr; end
      2:  o.srcb = 2'b11;
      3:  begin o.srca = 1'b1; o.srcb = 2'b10; end
      4:  begin o.mrd = 1'b1; o.iord = 1'b1; end
      5:  begin o.rw = 1'b1; o.m2r = 1'b1; end
      6:  begin o.mwr = 1'b1; o.iord = 1'b1; end
      7:  begin o.srca = 1'b1; o.aluop = 2'b10; end
      8:  begin o.rw = 1'b1; o.rdst = 1'b1; end
      9:  begin o.srca = 1'b1; o.aluop = 2'b01; o.pcwc = 1'b1; o.pcsrc = 2'b01; end
      10: begin o.pcw = 1'b1; o.pcsrc = 2'b10; end
      11: begin o.srca = 1'b1; o.srcb = 2'b10; end
      12: o.rw = 1'b1;
      13: o.ill = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] model_ir;

  task automatic check_val(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, sample at the falling
  // edge, then advance to just after the next rising edge.
  task automatic step(input logic [5:0] op, input logic mr, input int st,
                      input logic [CNT_W-1:0] ir, input string tag);
    opcode    = op;
    mem_ready = mr;
    @(negedge clk);
    check_val({tag, " state"}, 32'(state), 32'(st));
    check_val({tag, " outputs"}, 32'(act_out), 32'(exp_out(st, mr)));
    check_val({tag, " instret"}, instret, ir);
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
  endfunction

  // Issue one instruction with random memory stalls; the phase list per
  // instruction class comes straight from the instruction's life cycle.
  task automatic run_instr(input logic [5:0] op);
    int  phases[$];
    logic retires;
    logic [CNT_W-1:0] ir_now;
    retires = 1'b1;
    case (op)
      OP_LW:   phases = '{1, 2, 3, 4, 5};
      OP_SW:   phases = '{1, 2, 3, 6};
      OP_R:    phases = '{1, 2, 7, 8};
      OP_BEQ:  phases = '{1, 2, 9};
      OP_J:    phases = '{1, 2, 10};
      OP_ADDI: phases = '{1, 2, 11, 12};
      default: begin phases = '{1, 2, 13}; retires = 1'b0; end
    endcase
    ir_now = exp_q.pop_front();
    foreach (phases[i]) begin
      if (phases[i] inside {1, 4, 6}) begin
        repeat ($urandom_range(0, 2)) step(op, 1'b0, phases[i], ir_now, "rand stall");
        step(op, 1'b1, phases[i], ir_now, "rand ready");
      end else begin
        step(op, 1'($urandom_range(0, 1)), phases[i], ir_now, "rand phase");
      end
    end
    model_ir = ir_now + (retires ? 1 : 0);
    exp_q.push_back(model_ir);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [5:0]       op;
    logic             mr;
    int               st;
    logic [CNT_W-1:0] ir;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [5:0] rop;

    vecs = '{
      '{OP_LW,   1'b1, 0,  0}, '{OP_LW,   1'b1, 1,  0}, '{OP_LW,   1'b1, 2,  0},
      '{OP_LW,   1'b1, 3,  0}, '{OP_LW,   1'b1, 4,  0}, '{OP_LW,   1'b1, 5,  0},
      '{OP_BEQ,  1'b1, 1,  1}, '{OP_BEQ,  1'b1, 2,  1}, '{OP_BEQ,  1'b1, 9,  1},
      '{OP_J,    1'b1, 1,  2}, '{OP_J,    1'b1, 2,  2}, '{OP_J,    1'b1, 10, 2},
      '{OP_SW,   1'b1, 1,  3}, '{OP_SW,   1'b1, 2,  3}, '{OP_SW,   1'b1, 3,  3},
      '{OP_SW,   1'b0, 6,  3}, '{OP_SW,   1'b0, 6,  3}, '{OP_SW,   1'b0, 6,  3},
      '{OP_SW,   1'b1, 6,  3},
      '{OP_ADDI, 1'b0, 1,  4}, '{OP_ADDI, 1'b0, 1,  4}, '{OP_ADDI, 1'b1, 1,  4},
      '{OP_ADDI, 1'b1, 2,  4}, '{OP_ADDI, 1'b1, 11, 4}, '{OP_ADDI, 1'b1, 12, 4},
      '{OP_BAD,  1'b1, 1,  5}, '{OP_BAD,  1'b1, 2,  5}, '{OP_BAD,  1'b1, 13, 5},
      '{OP_R,    1'b1, 1,  5}, '{OP_R,    1'b0, 2,  5}, '{OP_R,    1'b0, 7,  5},
      '{OP_R,    1'b1, 8,  5},
      '{OP_LW,   1'b1, 1,  6}
    };

    // reset state while rst_n is held low
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = OP_LW;
    #1;
    check_val("reset state", 32'(state), 32'd0);
    check_val("reset outputs", 32'(act_out), 32'd0);
    check_val("reset instret", instret, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // directed table: one RST cycle, then lw, beq, j, stalled sw,
    // stalled-fetch addi, illegal, R-type; ends inside the next FETCH
    foreach (vecs[i]) step(vecs[i].op, vecs[i].mr, vecs[i].st, vecs[i].ir, "table");

    // finish the lw that the table left in FETCH, then go random
    step(OP_LW, 1'b1, 2, 6, "table tail");
    step(OP_LW, 1'b1, 3, 6, "table tail");
    step(OP_LW, 1'b1, 4, 6, "table tail");
    step(OP_LW, 1'b1, 5, 6, "table tail");
    model_ir = 7;
    exp_q.push_back(model_ir);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0: rop = OP_LW;
        1: rop = OP_SW;
        2: rop = OP_R;
        3: rop = OP_BEQ;
        4: rop = OP_J;
        5: rop = OP_ADDI;
        default: begin
          rop = 6'($urandom_range(0, 63));
          while (is_legal(rop)) rop = 6'($urandom_range(0, 63));
        end
      endcase
      run_instr(rop);
    end

    // reset in the middle of a stalled store
    model_ir = exp_q.pop_front();
    step(OP_SW, 1'b1, 1, model_ir, "midreset");
    step(OP_SW, 1'b1, 2, model_ir, "midreset");
    step(OP_SW, 1'b1, 3, model_ir, "midreset");
    step(OP_SW, 1'b0, 6, model_ir, "midreset");
    #1;
    check_val("midreset memwrite before", 32'(MemWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("midreset memwrite", 32'(MemWrite), 32'd0);
    check_val("midreset state", 32'(state), 32'd0);
    check_val("midreset instret", instret, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(OP_J, 1'b1, 0, 0, "after reset");
    step(OP_J, 1'b1, 1, 0, "after reset");
    step(OP_J, 1'b1, 2, 0, "after reset");
    step(OP_J, 1'b1, 10, 0, "after reset");
    step(OP_J, 1'b1, 1, 1, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
